ppgen_issue: RTL and testbench

- Producer end of the partial-product interface: accepts 8-bit unsigned operand pairs over a valid/ready stream, buffers them, and issues the 64-bit partial-product bus consumed by the compression trees.
- Buffering is in an N-entry FIFO, with a sequence tag attached to each issued entry.
- Sits between operand sources (or the built-in sweep generator) and the ppcom stage of each multiplier variant.
- Keeps pp bit ordering fixed so every tree variant sees identical weights.

---
 rtl/ppgen_issue.sv | 154 +++++++++++++++
 tb/tb_ppgen_issue.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppgen_issue.sv
// Partial-product issue stage: buffers 8x8 operand pairs in a DEPTH-entry FIFO and issues the
// 64-bit pp bus with a sequence tag. Define PPGEN_SWEEP_EN to add the exhaustive sweep generator.
`timescale 1ns/1ps
module ppgen_issue #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_pp,
  output logic [TAG_W-1:0] out_tag,
  output logic [15:0]      issue_cnt,
  input  logic             sweep_start,
  output logic             sweep_busy,
  output logic             sweep_done
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [7:0]       a_mem [DEPTH];
  logic [7:0]       b_mem [DEPTH];
  logic [TAG_W-1:0] t_mem [DEPTH];

  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [TAG_W-1:0] tag_cnt;
  logic             full;
  logic             push_en, pop_en;
  logic [7:0]       push_a, push_b;

  assign full      = (count == CW'(DEPTH));
  assign out_valid = (count != '0);
  assign pop_en    = out_valid && out_ready;

`ifdef PPGEN_SWEEP_EN
  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_DRAIN} state_t;
  state_t      state;
  logic [15:0] sc;

  assign in_ready = !full && (state == S_IDLE);

  always_comb begin
    push_en = in_valid && in_ready;
    push_a  = in_a;
    push_b  = in_b;
    if (state == S_SWEEP) begin
      push_en = !full;
      push_a  = sc[7:0];
      push_b  = sc[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      sc         <= '0;
      sweep_busy <= 1'b0;
      sweep_done <= 1'b0;
    end else begin
      sweep_done <= 1'b0;
      if (flush) begin
        state      <= S_IDLE;
        sweep_busy <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (sweep_start) begin
              state      <= S_SWEEP;
              sc         <= '0;
              sweep_busy <= 1'b1;
            end
          end
          S_SWEEP: begin
            if (!full) begin
              sc <= sc + 16'd1;
              if (sc == 16'hFFFF) state <= S_DRAIN;
            end
          end
          S_DRAIN: begin
            if (count == '0) begin
              state      <= S_IDLE;
              sweep_busy <= 1'b0;
              sweep_done <= 1'b1;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
`else
  logic unused_sweep_start;
  assign unused_sweep_start = sweep_start;
  assign in_ready   = !full;
  assign push_en    = in_valid && in_ready;
  assign push_a     = in_a;
  assign push_b     = in_b;
  assign sweep_busy = 1'b0;
  assign sweep_done = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      tag_cnt   <= '0;
      issue_cnt <= '0;
    end else if (flush) begin
      // tag_cnt and issue_cnt deliberately survive a flush
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) begin
        a_mem[wr_ptr] <= push_a;
        b_mem[wr_ptr] <= push_b;
        t_mem[wr_ptr] <= tag_cnt;
        wr_ptr        <= wr_ptr + PW'(1);
        tag_cnt       <= tag_cnt + TAG_W'(1);
      end
      if (pop_en) begin
        rd_ptr    <= rd_ptr + PW'(1);
        issue_cnt <= issue_cnt + 16'd1;
      end
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Row i of the bus is the multiplicand gated by multiplier bit i; zeroed while empty.
  always_comb begin
    out_pp  = '0;
    out_tag = '0;
    if (out_valid) begin
      out_tag = t_mem[rd_ptr];
      for (int unsigned i = 0; i < 8; i++) begin
        out_pp[8*i +: 8] = {8{b_mem[rd_ptr][i]}} & a_mem[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_ppgen_issue.sv
// Scoreboard bench for ppgen_issue: stimulus pushes expected {pp, tag}; a negedge monitor pops on each issue.
`timescale 1ns/1ps
module tb_ppgen_issue;
  localparam int DEPTH = 2;
  localparam int TAG_W = 4;

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, out_ready, sweep_start;
  logic [7:0]       in_a, in_b;
  logic             in_ready, out_valid, sweep_busy, sweep_done;
  logic [63:0]      out_pp;
  logic [TAG_W-1:0] out_tag;
  logic [15:0]      issue_cnt;

  always #5 clk = ~clk;

  ppgen_issue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_pp(out_pp), .out_tag(out_tag),
    .issue_cnt(issue_cnt),
    .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done)
  );

  typedef struct packed {
    logic [63:0]      pp;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t             exp_q[$];
  exp_t             mon_e;
  int               vectors = 0;
  int               miscompares = 0;
  logic [TAG_W-1:0] tag_m = '0;
  bit               sb_on = 1'b1;
  logic [63:0]      held;

  function automatic logic [63:0] pp_model(input logic [7:0] a, input logic [7:0] b);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++)
        r[8*i+j] = b[i] & a[j];
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%h, expected 0x%h", name, act, req);
    end
  endtask

  // Monitor: every handshake that the DUT will commit on the next edge is scored.
  always @(negedge clk) begin
    if (sb_on && !rst && !flush && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_issue: got pp 0x%h tag %0d, expected no output", out_pp, out_tag);
      end else begin
        mon_e = exp_q.pop_front();
        check("issue_pp", out_pp, mon_e.pp);
        check("issue_tag", 64'(out_tag), 64'(mon_e.tag));
      end
    end
  end

  task automatic step(input logic v, input logic [7:0] a, input logic [7:0] b,
                      input logic rdy, input logic fl, input logic [63:0] exp_pp);
    @(posedge clk); #1;
    in_valid = v; in_a = a; in_b = b; out_ready = rdy; flush = fl;
    @(negedge clk);
    if (fl) exp_q.delete();
    else if (v && in_ready) begin
      exp_q.push_back(exp_t'{exp_pp, tag_m});
      tag_m = tag_m + TAG_W'(1);
    end
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 8'h00, 8'h00, rdy, 1'b0, 64'h0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sweep_start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    tag_m = '0;
    @(negedge clk);
  endtask

  task automatic check_reset_state(input string pfx);
    check({pfx, "_in_ready"},  64'(in_ready),   64'd1);
    check({pfx, "_out_valid"}, 64'(out_valid),  64'd0);
    check({pfx, "_out_pp"},    out_pp,          64'd0);
    check({pfx, "_out_tag"},   64'(out_tag),    64'd0);
    check({pfx, "_issue_cnt"}, 64'(issue_cnt),  64'd0);
    check({pfx, "_busy"},      64'(sweep_busy), 64'd0);
    check({pfx, "_done"},      64'(sweep_done), 64'd0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sweep_start = 1'b0;
    in_a = '0; in_b = '0;
    do_reset();
    check_reset_state("reset");

    // single transfer, 1-cycle latency
    step(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 64'h00000000000000FF);
    idle(1'b1);
    check("latency_out_valid", 64'(out_valid), 64'd1);
    idle(1'b1);
    check("single_issue_cnt", 64'(issue_cnt), 64'd1);
    check("single_empty", 64'(out_valid), 64'd0);

    // backpressure fill and ordered drain
    do_reset();
    step(1'b1, 8'h03, 8'h05, 1'b0, 1'b0, 64'h0000000000030003);
    step(1'b1, 8'h81, 8'h80, 1'b0, 1'b0, 64'h8100000000000000);
    idle(1'b0);
    check("full_in_ready", 64'(in_ready), 64'd0);
    check("full_head_pp", out_pp, 64'h0000000000030003);
    held = out_pp;
    idle(1'b0);
    check("stall_hold_pp", out_pp, held);
    check("stall_hold_tag", 64'(out_tag), 64'd0);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    check("drain_issue_cnt", 64'(issue_cnt), 64'd2);
    check("drain_empty", 64'(out_valid), 64'd0);

    // continuous streaming, tag wrap
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 8'(i*37 + 5), 8'(i*11 + 1), 1'b1, 1'b0, pp_model(8'(i*37 + 5), 8'(i*11 + 1)));
      check("stream_in_ready", 64'(in_ready), 64'd1);
      if (i > 0) check("stream_out_valid", 64'(out_valid), 64'd1);
    end
    idle(1'b1);
    idle(1'b1);
    check("stream_issue_cnt", 64'(issue_cnt), 64'd20);

    // flush with full FIFO and in_valid held
    do_reset();
    step(1'b1, 8'h11, 8'h22, 1'b0, 1'b0, pp_model(8'h11, 8'h22));
    step(1'b1, 8'h33, 8'h44, 1'b0, 1'b0, pp_model(8'h33, 8'h44));
    step(1'b1, 8'h55, 8'h66, 1'b0, 1'b1, 64'h0);
    idle(1'b1);
    check("flush_out_valid", 64'(out_valid), 64'd0);
    check("flush_in_ready", 64'(in_ready), 64'd1);
    check("flush_issue_cnt", 64'(issue_cnt), 64'd0);
    step(1'b1, 8'hA5, 8'h5A, 1'b0, 1'b0, pp_model(8'hA5, 8'h5A));
    idle(1'b0);
    check("post_flush_tag", 64'(out_tag), 64'd2);
    idle(1'b1);
    idle(1'b0);
    check("post_flush_issue_cnt", 64'(issue_cnt), 64'd1);
    // flush colliding with both a push and a pop
    step(1'b1, 8'h01, 8'h02, 1'b0, 1'b0, pp_model(8'h01, 8'h02));
    step(1'b1, 8'h07, 8'h09, 1'b1, 1'b1, 64'h0);
    idle(1'b0);
    check("flush_pop_issue_cnt", 64'(issue_cnt), 64'd1);
    check("flush_pop_empty", 64'(out_valid), 64'd0);
    step(1'b1, 8'h0F, 8'hF0, 1'b0, 1'b0, pp_model(8'h0F, 8'hF0));
    idle(1'b0);
    check("flush_push_tag", 64'(out_tag), 64'd4);
    idle(1'b1);

    // reset mid-stall
    step(1'b1, 8'hC3, 8'h3C, 1'b0, 1'b0, pp_model(8'hC3, 8'h3C));
    step(1'b1, 8'h99, 8'h66, 1'b0, 1'b0, pp_model(8'h99, 8'h66));
    idle(1'b0);
    check("prerst_in_ready", 64'(in_ready), 64'd0);
    do_reset();
    check_reset_state("midrst");

`ifdef PPGEN_SWEEP_EN
    begin
      int  n;
      int  ir_viol;
      bit  done_seen;
      int  extra_done;
      for (int s = 0; s < 65536; s++) begin
        exp_q.push_back(exp_t'{pp_model(s[7:0], s[15:8]), TAG_W'(s)});
      end
      check("sweep_entry254_pp", exp_q[254].pp, pp_model(8'hFE, 8'h00));
      check("sweep_last_pp", exp_q[65535].pp, 64'hFFFFFFFFFFFFFFFF);
      @(posedge clk); #1;
      sweep_start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0; in_valid = 1'b1; in_a = 8'h5A; in_b = 8'hC3;
      @(negedge clk);
      check("sweep_busy_set", 64'(sweep_busy), 64'd1);
      n = 0; ir_viol = 0; done_seen = 1'b0;
      while (n < 70000 && !done_seen) begin
        @(negedge clk);
        if (sweep_busy && in_ready) ir_viol++;
        if (sweep_done) done_seen = 1'b1;
        n++;
      end
      in_valid = 1'b0;
      check("sweep_done_seen", 64'(done_seen), 64'd1);
      check("sweep_in_ready_low", 64'(ir_viol), 64'd0);
      check("sweep_all_issued", 64'(exp_q.size()), 64'd0);
      check("sweep_issue_cnt_wrap", 64'(issue_cnt), 64'd0);
      check("sweep_busy_drop", 64'(sweep_busy), 64'd0);
      extra_done = 0;
      for (int k = 0; k < 10; k++) begin
        @(negedge clk);
        if (sweep_done) extra_done++;
      end
      check("sweep_done_once", 64'(extra_done), 64'd0);

      // flush mid-sweep aborts without sweep_done
      do_reset();
      sb_on = 1'b0;
      @(posedge clk); #1;
      sweep_start = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      sweep_start = 1'b0;
      repeat (50) @(posedge clk);
      #1 flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(sweep_busy), 64'd0);
      check("abort_out_valid", 64'(out_valid), 64'd0);
      check("abort_in_ready", 64'(in_ready), 64'd1);
      extra_done = 0;
      for (int k = 0; k < 20; k++) begin
        @(negedge clk);
        if (sweep_done || out_valid) extra_done++;
      end
      check("abort_no_done", 64'(extra_done), 64'd0);
      exp_q.delete();
      sb_on = 1'b1;
    end
`else
    @(posedge clk); #1;
    sweep_start = 1'b1;
    @(posedge clk); #1;
    sweep_start = 1'b0;
    @(negedge clk);
    check("nosweep_busy", 64'(sweep_busy), 64'd0);
    check("nosweep_out_valid", 64'(out_valid), 64'd0);
`endif

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
